// File: rtl/mul_operand_dispatcher.sv
// mul_operand_dispatcher
// Feeds operand pairs from a small FIFO into a sequential signed multiplier
// and collects each product into a valid/ready output register.
// Optional build macro: MUL_TIMEOUT_EN (adds a WAIT-state timeout that
// returns a zero product flagged with out_err).
//
// Handshake: a transfer on in_* or out_* happens on a rising clk edge where
// valid and ready are both high; valid never depends on ready, and the
// payload is held stable while valid && !ready.
module mul_operand_dispatcher #(
  parameter int NB          = 32,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 72
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NB-1:0]              in_a,
  input  logic [NB-1:0]              in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*NB-1:0]            out_product,
  output logic                       out_err,
  output logic                       mul_start,
  output logic [NB-1:0]              mul_a,
  output logic [NB-1:0]              mul_b,
  input  logic [2*NB-1:0]            mul_product,
  input  logic                       mul_ready,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_STALL} state_t;

  state_t             state_q;
  logic               mul_start_q;
  logic [NB-1:0]      mul_a_q, mul_b_q;
  logic               skip_q;
  logic               out_valid_q;
  logic [2*NB-1:0]    out_product_q;
  logic [2*NB-1:0]    hold_q;

  logic [2*NB-1:0]    mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]      level_q;

  logic               full, empty, push, pop;
  logic               mul_done, tmo_fire, res_take, out_free;
  logic [2*NB-1:0]    res_data;

  // FIFO status; a full FIFO refuses pushes even on a popping cycle.
  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign in_ready = rst_n && !full;
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == S_IDLE) && !empty;

  // The first WAIT cycle may still see the previous operation's ready.
  assign mul_done = (state_q == S_WAIT) && !skip_q && mul_ready;
  assign res_take = mul_done || tmo_fire;
  assign res_data = mul_done ? mul_product : '0;
  assign out_free = !out_valid_q || out_ready;

  assign out_valid   = out_valid_q;
  assign out_product = out_product_q;
  assign mul_start   = mul_start_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign busy        = (state_q != S_IDLE) || !empty;
  assign fifo_level  = level_q;

  // Operand storage; entries need no reset because level_q gates reads.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_a, in_b};
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Issue/collect FSM with registered start pulse, operands and result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      mul_start_q   <= 1'b0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      skip_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      hold_q        <= '0;
    end else begin
      mul_start_q <= 1'b0;
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            {mul_a_q, mul_b_q} <= mem_q[rd_ptr_q];
            mul_start_q        <= 1'b1;
            state_q            <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          skip_q  <= 1'b1;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          skip_q <= 1'b0;
          if (res_take) begin
            if (out_free) begin
              out_product_q <= res_data;
              out_valid_q   <= 1'b1;
              state_q       <= S_IDLE;
            end else begin
              hold_q  <= res_data;
              state_q <= S_STALL;
            end
          end
        end
        S_STALL: begin
          if (out_ready) begin
            out_product_q <= hold_q;
            out_valid_q   <= 1'b1;
            state_q       <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MUL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC+1);

  logic [CW-1:0] tmo_cnt_q;
  logic          out_err_q, hold_err_q;

  assign tmo_fire = (state_q == S_WAIT) && !mul_done &&
                    (tmo_cnt_q == CW'(TIMEOUT_CYC-1));
  assign out_err  = out_err_q;

  // WAIT cycle counter and the error flag that travels with each result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q  <= '0;
      out_err_q  <= 1'b0;
      hold_err_q <= 1'b0;
    end else begin
      if (state_q == S_ISSUE)     tmo_cnt_q <= '0;
      else if (state_q == S_WAIT) tmo_cnt_q <= tmo_cnt_q + CW'(1);
      if (res_take) begin
        if (out_free) out_err_q  <= tmo_fire;
        else          hold_err_q <= tmo_fire;
      end else if ((state_q == S_STALL) && out_ready) begin
        out_err_q <= hold_err_q;
      end
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^32'(TIMEOUT_CYC);
  assign tmo_fire   = 1'b0;
  assign out_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mul_operand_dispatcher.sv
// Directed bench for mul_operand_dispatcher with a behavioural sequential
// multiplier that keeps its old ready/product for one cycle after a start.
module tb_mul_operand_dispatcher;
  localparam int NB    = 32;
  localparam int DEPTH = 4;
  localparam int LAT   = 4;

  // clock / reset and DUT connections
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [NB-1:0]   in_a = '0, in_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [2*NB-1:0] out_product;
  logic            out_err;
  logic            mul_start;
  logic [NB-1:0]   mul_a, mul_b;
  logic [2*NB-1:0] mul_product = '0;
  logic            mul_ready = 1'b1;
  logic            busy;
  logic [$clog2(DEPTH+1)-1:0] fifo_level;

  logic            mul_hang = 1'b0;
  int              m_cnt = 0;
  logic [63:0]     m_prod = '0;

  int              n_vec = 0;
  int              n_miss = 0;
  int              start_total = 0;
  logic [64:0]     got_q[$];
  logic            st;
  int              lv;

  logic [NB-1:0]   va [6];
  logic [NB-1:0]   vb [6];
  logic [63:0]     vp [6];

  always #5 clk = ~clk;

  mul_operand_dispatcher #(.NB(NB), .DEPTH(DEPTH), .TIMEOUT_CYC(72)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .out_err(out_err), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product), .mul_ready(mul_ready), .busy(busy),
    .fifo_level(fifo_level)
  );

  // Multiplier model: restarts on every start; ready drops one cycle later.
  always @(posedge clk) begin
    if (mul_start) begin
      m_cnt  <= LAT;
      m_prod <= {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
    end else if (m_cnt != 0) begin
      if (m_cnt == LAT) mul_ready <= 1'b0;
      if (m_cnt == 1 && !mul_hang) begin
        mul_ready   <= 1'b1;
        mul_product <= m_prod;
      end
      m_cnt <= m_cnt - 1;
    end
  end

  // Result monitor: records every accepted result as {err, product}.
  always @(negedge clk) begin
    if (mul_start) start_total++;
    if (rst_n && out_valid && out_ready) got_q.push_back({out_err, out_product});
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [NB-1:0] a, input logic [NB-1:0] b,
                      output logic stalled, output int lvl);
    int n;
    n = 0; stalled = 1'b0; lvl = -1;
    while (!in_ready && n < 400) begin
      if (!stalled) lvl = int'(fifo_level);
      stalled = 1'b1;
      step();
      n++;
    end
    in_valid = 1'b1; in_a = a; in_b = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    n_vec++; if (in_ready !== 1'b0) begin n_miss++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
    n_vec++; if (out_err !== 1'b0) begin n_miss++; $display("FAIL rst_out_err got=%0b exp=0", out_err); end
    n_vec++; if (mul_start !== 1'b0) begin n_miss++; $display("FAIL rst_mul_start got=%0b exp=0", mul_start); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    n_vec++; if (out_product !== 64'd0) begin n_miss++; $display("FAIL rst_out_product got=%h exp=0", out_product); end
    n_vec++; if ({mul_a, mul_b} !== 64'd0) begin n_miss++; $display("FAIL rst_mul_ab got=%h exp=0", {mul_a, mul_b}); end
    n_vec++; if (fifo_level !== 3'd0) begin n_miss++; $display("FAIL rst_level got=%0d exp=0", fifo_level); end
    rst_n = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL rst_release_in_ready got=%0b exp=1", in_ready); end
    step();
  endtask

  task automatic test_single();
    int start_cnt, start_k, rdy_k, ov_k;
    logic [63:0] prod_at_ov;
    logic        err_at_ov;
    start_cnt = 0; start_k = 0; rdy_k = 0; ov_k = 0;
    prod_at_ov = '0; err_at_ov = 1'bx;
    out_ready = 1'b1;
    got_q.delete();
    push(32'd3, 32'hFFFF_FFFB, st, lv);
    n_vec++; if (fifo_level !== 3'd1) begin n_miss++; $display("FAIL single_no_bypass level got=%0d exp=1", fifo_level); end
    for (int k = 1; k <= 12; k++) begin
      step();
      if (mul_start) begin
        start_cnt++;
        if (start_k == 0) begin
          start_k = k;
          n_vec++; if ({mul_a, mul_b} !== {32'd3, 32'hFFFF_FFFB}) begin n_miss++; $display("FAIL single_operands got=%h exp=%h", {mul_a, mul_b}, {32'd3, 32'hFFFF_FFFB}); end
        end
      end
      if (k >= 3 && mul_ready && rdy_k == 0) rdy_k = k;
      if (out_valid && ov_k == 0) begin ov_k = k; prod_at_ov = out_product; err_at_ov = out_err; end
    end
    n_vec++; if (start_cnt != 1) begin n_miss++; $display("FAIL single_start_count got=%0d exp=1", start_cnt); end
    n_vec++; if (start_k != 1) begin n_miss++; $display("FAIL single_start_cycle got=%0d exp=1", start_k); end
    n_vec++; if (rdy_k != 6) begin n_miss++; $display("FAIL single_model_ready_cycle got=%0d exp=6", rdy_k); end
    n_vec++; if (ov_k != 7) begin n_miss++; $display("FAIL single_out_valid_cycle got=%0d exp=7", ov_k); end
    n_vec++; if (prod_at_ov !== 64'hFFFF_FFFF_FFFF_FFF1) begin n_miss++; $display("FAIL single_product got=%h exp=FFFFFFFFFFFFFFF1", prod_at_ov); end
    n_vec++; if (err_at_ov !== 1'b0) begin n_miss++; $display("FAIL single_err got=%b exp=0", err_at_ov); end
    n_vec++; if (got_q.size() != 1) begin n_miss++; $display("FAIL single_result_count got=%0d exp=1", got_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic st5, st6;
    int   lv6;
    va = '{32'd3, 32'hFFFF_FFFE, 32'd100000, 32'hFFFF_FFFF, 32'h1234_5678, 32'd0};
    vb = '{32'd7, 32'd9, 32'd100000, 32'hFFFF_FFFF, 32'h0000_0010, 32'hFFFF_FF85};
    vp = '{64'd21, 64'hFFFF_FFFF_FFFF_FFEE, 64'h0000_0002_540B_E400,
           64'd1, 64'h0000_0001_2345_6780, 64'd0};
    out_ready = 1'b1;
    got_q.delete();
    st5 = 1'b0; st6 = 1'b0; lv6 = -1;
    for (int i = 0; i < 6; i++) begin
      push(va[i], vb[i], st, lv);
      if (i == 4) st5 = st;
      if (i == 5) begin st6 = st; lv6 = lv; end
    end
    for (int i = 0; i < 300 && got_q.size() < 6; i++) step();
    n_vec++; if (st5 !== 1'b0) begin n_miss++; $display("FAIL b2b_fifth_stalled got=%b exp=0", st5); end
    n_vec++; if (st6 !== 1'b1) begin n_miss++; $display("FAIL b2b_sixth_stalled got=%b exp=1", st6); end
    n_vec++; if (lv6 != 4) begin n_miss++; $display("FAIL b2b_level_at_stall got=%0d exp=4", lv6); end
    n_vec++; if (got_q.size() != 6) begin n_miss++; $display("FAIL b2b_result_count got=%0d exp=6", got_q.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < got_q.size()) begin
        n_vec++; if (got_q[i] !== {1'b0, vp[i]}) begin n_miss++; $display("FAIL b2b_result%0d got=%h exp=%h", i, got_q[i], {1'b0, vp[i]}); end
      end
    end
  endtask

  task automatic test_extremes();
    out_ready = 1'b1;
    got_q.delete();
    push(32'h8000_0000, 32'h8000_0000, st, lv);
    push(32'h7FFF_FFFF, 32'h8000_0000, st, lv);
    for (int i = 0; i < 100 && got_q.size() < 2; i++) step();
    n_vec++; if (got_q.size() != 2) begin n_miss++; $display("FAIL ext_result_count got=%0d exp=2", got_q.size()); end
    if (got_q.size() >= 2) begin
      n_vec++; if (got_q[0] !== {1'b0, 64'h4000_0000_0000_0000}) begin n_miss++; $display("FAIL ext_min_min got=%h exp=04000000000000000", got_q[0]); end
      n_vec++; if (got_q[1] !== {1'b0, 64'hC000_0000_8000_0000}) begin n_miss++; $display("FAIL ext_max_min got=%h exp=0C000000080000000", got_q[1]); end
    end
  endtask

  task automatic test_stall();
    int s0, bad;
    logic seen;
    got_q.delete();
    out_ready = 1'b0;
    s0 = start_total;
    push(32'd5, 32'd5, st, lv);
    push(32'hFFFF_FFF9, 32'd3, st, lv);
    push(32'd11, 32'hFFFF_FFF5, st, lv);
    bad = 0; seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (out_valid) seen = 1'b1;
      else if (seen) bad++;
      if (seen && out_product !== 64'd25) bad++;
    end
    n_vec++; if (seen !== 1'b1) begin n_miss++; $display("FAIL stall_first_valid got=%b exp=1", seen); end
    n_vec++; if (bad != 0) begin n_miss++; $display("FAIL stall_output_stable unstable_cycles=%0d exp=0", bad); end
    n_vec++; if (start_total - s0 != 2) begin n_miss++; $display("FAIL stall_start_count got=%0d exp=2", start_total - s0); end
    n_vec++; if (fifo_level !== 3'd1) begin n_miss++; $display("FAIL stall_level got=%0d exp=1", fifo_level); end
    n_vec++; if (busy !== 1'b1) begin n_miss++; $display("FAIL stall_busy got=%b exp=1", busy); end
    out_ready = 1'b1;
    step();
    n_vec++; if ({out_valid, out_product} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFEB}) begin n_miss++; $display("FAIL stall_second_consecutive got=%h exp=1FFFFFFFFFFFFFFEB", {out_valid, out_product}); end
    for (int i = 0; i < 100 && got_q.size() < 3; i++) step();
    n_vec++; if (got_q.size() != 3) begin n_miss++; $display("FAIL stall_result_count got=%0d exp=3", got_q.size()); end
    if (got_q.size() >= 3) begin
      n_vec++; if (got_q[0] !== {1'b0, 64'd25}) begin n_miss++; $display("FAIL stall_result0 got=%h exp=25", got_q[0]); end
      n_vec++; if (got_q[1] !== {1'b0, 64'hFFFF_FFFF_FFFF_FFEB}) begin n_miss++; $display("FAIL stall_result1 got=%h exp=FFFFFFFFFFFFFFEB", got_q[1]); end
      n_vec++; if (got_q[2] !== {1'b0, 64'hFFFF_FFFF_FFFF_FF87}) begin n_miss++; $display("FAIL stall_result2 got=%h exp=FFFFFFFFFFFFFF87", got_q[2]); end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    push(32'd9, 32'd9, st, lv);
    push(32'd2, 32'd2, st, lv);
    step();
    step();
    rst_n = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_miss++; $display("FAIL rmid_in_ready got=%b exp=0", in_ready); end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL rmid_out_valid got=%b exp=0", out_valid); end
    n_vec++; if (fifo_level !== 3'd0) begin n_miss++; $display("FAIL rmid_level got=%0d exp=0", fifo_level); end
    n_vec++; if (mul_start !== 1'b0) begin n_miss++; $display("FAIL rmid_mul_start got=%b exp=0", mul_start); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    n_vec++; if (out_product !== 64'd0) begin n_miss++; $display("FAIL rmid_out_product got=%h exp=0", out_product); end
    n_vec++; if (mul_a !== 32'd0) begin n_miss++; $display("FAIL rmid_mul_a got=%h exp=0", mul_a); end
    rst_n = 1'b1;
    got_q.delete();
    push(32'd7, 32'd6, st, lv);
    for (int i = 0; i < 100 && got_q.size() < 1; i++) step();
    repeat (20) step();
    n_vec++; if (got_q.size() != 1) begin n_miss++; $display("FAIL rmid_result_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() >= 1) begin
      n_vec++; if (got_q[0] !== {1'b0, 64'd42}) begin n_miss++; $display("FAIL rmid_result got=%h exp=42", got_q[0]); end
    end
  endtask

  task automatic test_timeout();
    int ov_k;
    out_ready = 1'b0;
    mul_hang = 1'b1;
    got_q.delete();
    push(32'd1, 32'd1, st, lv);
    ov_k = 0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (out_valid && ov_k == 0) ov_k = k;
    end
`ifdef MUL_TIMEOUT_EN
    n_vec++; if (ov_k != 74) begin n_miss++; $display("FAIL tmo_valid_cycle got=%0d exp=74", ov_k); end
    n_vec++; if (out_err !== 1'b1) begin n_miss++; $display("FAIL tmo_err got=%b exp=1", out_err); end
    n_vec++; if (out_product !== 64'd0) begin n_miss++; $display("FAIL tmo_product got=%h exp=0", out_product); end
`else
    n_vec++; if (ov_k != 0) begin n_miss++; $display("FAIL notmo_valid_cycle got=%0d exp=0", ov_k); end
    n_vec++; if (out_err !== 1'b0) begin n_miss++; $display("FAIL notmo_err got=%b exp=0", out_err); end
    n_vec++; if (busy !== 1'b1) begin n_miss++; $display("FAIL notmo_busy got=%b exp=1", busy); end
`endif
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    mul_hang = 1'b0;
    step();
  endtask

  // Watchdog for anything that escapes the bounded loops.
  initial begin
    #400000;
    $display("FAIL watchdog expired n_vec=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_extremes();
    test_stall();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mul_operand_dispatcher.md
Name: mul_operand_dispatcher

Overview:
- Upstream feeder and result collector for the sequential 32-bit signed multiplier (multiplier4).
- Buffers operand pairs in a small FIFO behind a valid/ready interface and issues one-cycle mul_start pulses with operands held.
- Waits for the multiplier's ready, then presents the signed product on a valid/ready output register.
- Keeps the multi-cycle multiplier busy back-to-back without the producer tracking its latency.

Parameters:
- NB, 32: operand width; product width is 2*NB.
- DEPTH, 4: operand FIFO entries; power of 2, at least 2.
- TIMEOUT_CYC, 72: WAIT-state cycle limit. Used only with MUL_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept; equals !full, forced 0 while rst_n=0.
- in_a  in  NB  signed operand A.
- in_b  in  NB  signed operand B.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  consumer accepts the result.
- out_product  out  2*NB  signed product.
- out_err  out  1  result produced by timeout; constant 0 without the macro.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a  out  NB  registered operand A; held stable from the start cycle until the next pop.
- mul_b  out  NB  registered operand B; same holding rule as mul_a.
- mul_product  in  2*NB  multiplier Product.
- mul_ready  in  1  multiplier ready/done.
- busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.
- fifo_level  out  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM goes to IDLE; FIFO pointers and level are cleared.
  - out_valid, out_err, mul_start and busy are 0.
  - out_product, mul_a and mul_b are 0.
  - Reset mid-operation abandons the in-flight multiply. The multiplier restarts on every start pulse, so no drain is needed.
- FIFO:
  - Push when in_valid && in_ready.
  - Pop only in IDLE when non-empty.
  - No bypass: a pair pushed into an empty FIFO is popped the following cycle at the earliest.
  - When full, in_ready=0 even if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave the level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: if the FIFO is non-empty, pop into mul_a/mul_b and go to ISSUE. Otherwise stay; mul_ready is ignored.
  - ISSUE: mul_start=1 for exactly this cycle; go to WAIT and set the skip flag.
  - WAIT:
    - In the first WAIT cycle, mul_ready is ignored, since a stale ready from the previous operation may still be high.
    - Afterwards, on mul_ready=1: if (!out_valid || out_ready), load out_product<=mul_product, set out_valid=1, out_err=0, and go to IDLE.
    - Otherwise capture mul_product into a holding register and go to STALL.
  - STALL: when out_ready=1, move the held product into the output register on the same edge (out_valid stays 1) and go to IDLE.
- Output handshake:
  - out_valid clears on out_ready unless a new load happens on the same edge.
  - out_product and out_err are stable while out_valid && !out_ready.
- Latency:
  - Push at edge t into an empty FIFO with the FSM in IDLE: pop at t+1, mul_start high during cycle t+1..t+2.
  - out_valid rises on the edge after mul_ready is first sampled in WAIT.
  - Throughput is one result per multiplier latency plus 3 cycles.
- Arithmetic: two's-complement signed. The product is passed through unmodified; no rounding or saturation.
- Ordering: results leave strictly in push order.

Optional Feature:
- Macro: MUL_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT, cleared on ISSUE.
  - If it reaches TIMEOUT_CYC without an accepted mul_ready, the result path loads out_product=0 and out_err=1 (with the same STALL rules) and goes to IDLE.
  - The next mul_start restarts the multiplier.
- Undefined: no counter; WAIT lasts indefinitely; out_err is tied to 0.

Test Plan:
- Reset, then push A=3, B=-5 with out_ready=1 -> mul_start high for exactly 1 cycle; out_product=0xFFFFFFFFFFFFFFF1; out_valid rises 1 edge after mul_ready is sampled; out_err=0.
- Push 6 random pairs back-to-back with out_ready=1 -> in_ready drops when fifo_level=4 (6th pair stalled until the next pop); all 6 products match A*B in push order.
- Push 0x80000000×0x80000000, then 0x7FFFFFFF×0x80000000 -> results 0x4000000000000000 and 0xC000000080000000, in that order.
- Hold out_ready=0 for 100 cycles with 2 pairs queued -> first result stable; second reaches STALL; no third mul_start; on release both results are delivered in order on consecutive accepts.
- Drive rst_n=0 for 1 cycle mid-WAIT -> next cycle out_valid=0, fifo_level=0, mul_start=0; then push 7×6 -> out_product=42.
- With MUL_TIMEOUT_EN, hold mul_ready=0 after a push -> 72 WAIT cycles, then out_valid=1, out_err=1, out_product=0. Without the macro -> out_valid stays 0 for at least 200 cycles.
